// File: rtl/hera_mem_pkg.sv
// hera_mem_pkg: shared types and constants for the HERA memory arbiter.
//   arb_state_t      - arbiter FSM states (issue / completion cycles)
//   PROT_TOP_DEFAULT - default boundary of the write-protected code region
package hera_mem_pkg;

    typedef enum logic [1:0] {
        ARB       = 2'd0,  // issue cycle: pick a requester, drive the SRAM
        CPU_DONE  = 2'd1,  // completion of a CPU access, core released
        HOST_DONE = 2'd2   // completion of a host access, response pulse
    } arb_state_t;

    localparam logic [15:0] PROT_TOP_DEFAULT = 16'h0100;

endpackage

// File: rtl/hera_mem_arbiter.sv
// hera_mem_arbiter: shares one single-port, 1-cycle-latency SRAM between the
// HERA core and a host loader/debug port. Every grant is two cycles (issue in
// ARB, then a completion cycle). The core is stalled except in its completion
// cycle. CPU writes below PROT_TOP are dropped and latch prot_fault.
//
// Ports
//   clock, reset       rising-edge clock, synchronous active-high reset
//   cpu_*              core port; cpu_stall gates the core clock enable,
//                      cpu_rdata valid while cpu_stall=0
//   host_halt          keeps the core off the bus entirely
//   host_valid/ready   host request handshake
//   host_rsp_valid     1-cycle completion pulse, host_rdata valid with it
//   ram_*              SRAM port (ram_rdata arrives the cycle after ram_en)
//   prot_fault         sticky: a CPU write hit the protected region
//   stall_cycles       saturating count of non-halted stall cycles
module hera_mem_arbiter
    import hera_mem_pkg::*;
#(
    parameter logic [15:0] PROT_TOP = PROT_TOP_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      cpu_addr,
    input  logic             cpu_code,
    input  logic             cpu_write,
    input  logic [15:0]      cpu_wdata,
    output logic [15:0]      cpu_rdata,
    output logic             cpu_stall,
    input  logic             host_halt,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic             host_write,
    input  logic [15:0]      host_addr,
    input  logic [15:0]      host_wdata,
    output logic             host_rsp_valid,
    output logic [15:0]      host_rdata,
    output logic             ram_en,
    output logic             ram_we,
    output logic [15:0]      ram_addr,
    output logic [15:0]      ram_wdata,
    input  logic [15:0]      ram_rdata,
    output logic             prot_fault,
    output logic [CNT_W-1:0] stall_cycles
);

    arb_state_t state;
    logic       last_host;   // 1: host held the last grant, CPU wins a tie
    logic       host_pend;   // host access issued, response owed
    logic       grant_host;
    logic       grant_cpu;
    logic       cpu_wr_ok;

    // Fetch vs. data access makes no difference to protection or arbitration.
    logic unused_cpu_code;
    assign unused_cpu_code = cpu_code;

    assign cpu_wr_ok = cpu_write && (cpu_addr >= PROT_TOP);

    // Grant decision exists only in the issue cycle; reset masks it so the
    // SRAM sees no access while reset is held.
    always_comb begin
        grant_host = 1'b0;
        grant_cpu  = 1'b0;
        if (!reset && state == ARB) begin
            if (host_halt)
                grant_host = host_valid;
            else if (host_valid && !last_host)
                grant_host = 1'b1;
            else
                grant_cpu = 1'b1;
        end
    end

    assign ram_en    = grant_host | grant_cpu;
    assign ram_we    = grant_host ? host_write : (grant_cpu & cpu_wr_ok);
    assign ram_addr  = grant_host ? host_addr  : cpu_addr;
    assign ram_wdata = grant_host ? host_wdata : cpu_wdata;

    assign host_ready     = grant_host;
    assign host_rsp_valid = !reset && host_pend && (state == HOST_DONE);
    assign host_rdata     = ram_rdata;
    assign cpu_rdata      = ram_rdata;
    assign cpu_stall      = reset || (state != CPU_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ARB;
            last_host    <= 1'b1;
            host_pend    <= 1'b0;
            prot_fault   <= 1'b0;
            stall_cycles <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (grant_host) begin
                        state     <= HOST_DONE;
                        last_host <= 1'b1;
                        host_pend <= 1'b1;
                    end else if (grant_cpu) begin
                        state     <= CPU_DONE;
                        last_host <= 1'b0;
                        if (cpu_write && !cpu_wr_ok)
                            prot_fault <= 1'b1;
                    end
                end
                CPU_DONE:  state <= ARB;
                HOST_DONE: begin
                    state     <= ARB;
                    host_pend <= 1'b0;
                end
                default:   state <= ARB;
            endcase

            // Halted cycles are deliberate, not contention; leave them out.
            if (cpu_stall && !host_halt && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hera_mem_arbiter.sv
// tb_hera_mem_arbiter: directed checks with literal expectations plus a
// randomized phase, all compared every cycle against a transaction-level model.
module tb_hera_mem_arbiter;

    localparam int          CNT_W = 4;
    localparam logic [15:0] PROT  = 16'h0100;
    localparam int          SAT   = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic [15:0]      cpu_addr, cpu_wdata, cpu_rdata;
    logic             cpu_code, cpu_write, cpu_stall;
    logic             host_halt, host_valid, host_ready, host_write, host_rsp_valid;
    logic [15:0]      host_addr, host_wdata, host_rdata;
    logic             ram_en, ram_we;
    logic [15:0]      ram_addr, ram_wdata, ram_rdata;
    logic             prot_fault;
    logic [CNT_W-1:0] stall_cycles;

    int tests = 0;
    int fails = 0;

    hera_mem_arbiter #(.PROT_TOP(PROT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_code(cpu_code), .cpu_write(cpu_write),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_halt(host_halt), .host_valid(host_valid), .host_ready(host_ready),
        .host_write(host_write), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rsp_valid(host_rsp_valid), .host_rdata(host_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .prot_fault(prot_fault), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    // Physical SRAM: registered read, read-old on write.
    logic [15:0] sram [0:65535];
    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we) sram[ram_addr] <= ram_wdata;
            ram_rdata <= sram[ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Memory contents as the spec's rules say they must be, plus the single
    // access in flight (owner, kind, data it must return).
    logic [15:0] ref_mem [0:65535];
    bit          m_busy, m_host_owner, m_is_write, m_host_next, m_fault;
    logic [15:0] m_data;
    int          m_cnt;
    bit          obs_stall, obs_ready;

    initial begin
        m_busy = 0; m_host_owner = 0; m_is_write = 0; m_host_next = 0;
        m_fault = 0; m_cnt = 0; m_data = '0;
    end

    always @(negedge clock) begin
        bit e_stall, e_en, e_we, e_ready, e_rsp, g_host, g_cpu;
        logic [15:0] e_addr, e_wdata;
        obs_stall = cpu_stall;
        obs_ready = host_ready;
        e_stall = 1; e_en = 0; e_we = 0; e_ready = 0; e_rsp = 0;
        e_addr = '0; e_wdata = '0;
        if (reset) begin
            chk("rst_stall", cpu_stall, 1);
            chk("rst_ready", host_ready, 0);
            chk("rst_rsp", host_rsp_valid, 0);
            chk("rst_en", ram_en, 0);
            m_busy = 0; m_host_next = 0; m_cnt = 0; m_fault = 0;
        end else begin
            g_host = 0; g_cpu = 0;
            if (m_busy) begin
                if (m_host_owner) e_rsp = 1;
                else              e_stall = 0;
            end else begin
                g_host = host_halt ? host_valid : (host_valid && m_host_next);
                g_cpu  = !host_halt && !g_host;
                if (g_host) begin
                    e_en = 1; e_ready = 1; e_we = host_write;
                    e_addr = host_addr; e_wdata = host_wdata;
                end else if (g_cpu) begin
                    e_en = 1; e_we = cpu_write && cpu_addr >= PROT;
                    e_addr = cpu_addr; e_wdata = cpu_wdata;
                end
            end
            chk("stall", cpu_stall, e_stall);
            chk("ready", host_ready, e_ready);
            chk("rsp", host_rsp_valid, e_rsp);
            chk("ram_en", ram_en, e_en);
            chk("fault", prot_fault, m_fault);
            chk("stall_cycles", stall_cycles, m_cnt);
            if (e_en) begin
                chk("ram_we", ram_we, e_we);
                chk("ram_addr", ram_addr, e_addr);
                chk("ram_wdata", ram_wdata, e_wdata);
            end
            if (m_busy && !m_is_write) begin
                if (m_host_owner) chk("host_rdata", host_rdata, m_data);
                else              chk("cpu_rdata", cpu_rdata, m_data);
            end
            // advance
            if (e_stall && !host_halt && m_cnt < SAT) m_cnt++;
            if (m_busy) m_busy = 0;
            else if (e_en) begin
                m_busy = 1;
                m_host_owner = g_host;
                m_is_write = g_host ? host_write : cpu_write;
                m_data = ref_mem[e_addr];
                if (e_we) ref_mem[e_addr] = e_wdata;
                if (g_cpu && cpu_write && cpu_addr < PROT) m_fault = 1;
                m_host_next = g_cpu;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cpu_done(input string nm);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (!cpu_stall) return;
        end
        chk({nm, "_timeout"}, 1, 0);
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
        wait_cpu_done("cpu_read_pre");
        @(posedge clock); #1;
        cpu_addr = a; cpu_write = 0;
        wait_cpu_done("cpu_read");
        d = cpu_rdata;
    endtask

    task automatic cpu_op(input logic [15:0] a, input logic [15:0] d,
                          output logic en, output logic we);
        wait_cpu_done("cpu_op_pre");
        @(posedge clock); #1;
        cpu_addr = a; cpu_write = 1; cpu_wdata = d;
        @(negedge clock);
        en = ram_en; we = ram_we;
        @(negedge clock);
    endtask

    task automatic host_req(input logic wr, input logic [15:0] a,
                            input logic [15:0] d, input bit abort);
        bit got = 0;
        int waited = 0;
        @(posedge clock); #1;
        host_valid = 1; host_write = wr; host_addr = a; host_wdata = d;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (host_ready) begin got = 1; waited = i; break; end
        end
        chk("host_accept", got, 1);
        chk("host_wait_le2", waited <= 2, 1);
        @(posedge clock); #1;
        host_valid = 0;
        if (abort) reset = 1;
        @(negedge clock);
        chk("host_rsp_lat", host_rsp_valid, abort ? 0 : 1);
    endtask

    task automatic reset_hold();
        @(posedge clock); #1;
        reset = 1; host_valid = 0; host_halt = 0; cpu_write = 0; cpu_addr = 0;
        @(posedge clock); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] d;
        logic en, we;
        int pulses;
        bit stall_low;
        for (int i = 0; i < 65536; i++) begin
            sram[i]    = 16'(i * 3) ^ 16'hA5A5;
            ref_mem[i] = 16'(i * 3) ^ 16'hA5A5;
        end
        sram[0] = 16'h1234; ref_mem[0] = 16'h1234;
        reset = 1; cpu_addr = 0; cpu_code = 1; cpu_write = 0; cpu_wdata = 0;
        host_halt = 0; host_valid = 0; host_write = 0; host_addr = 0; host_wdata = 0;
        @(posedge clock); @(negedge clock);
        chk("lit_rst_cnt", stall_cycles, 0);
        chk("lit_rst_fault", prot_fault, 0);
        @(posedge clock); #1 reset = 0;

        // CPU read of 0x0000: issue in cycle 1, data in cycle 2, then 1,0 pattern
        @(negedge clock);
        chk("lit_c1_en", ram_en, 1);
        chk("lit_c1_stall", cpu_stall, 1);
        @(negedge clock);
        chk("lit_c2_stall", cpu_stall, 0);
        chk("lit_c2_rdata", cpu_rdata, 16'h1234);
        @(negedge clock);
        chk("lit_c3_stall", cpu_stall, 1);
        @(negedge clock);
        chk("lit_c4_stall", cpu_stall, 0);

        // Host write under contention, then the CPU reads it back
        host_req(1, 16'h0040, 16'hBEEF, 0);
        cpu_read(16'h0040, d);
        chk("lit_beef", d, 16'hBEEF);

        // Halted: four back-to-back host reads from the first cycle after reset
        reset_hold();
        reset = 0; host_halt = 1; host_valid = 1; host_write = 0; host_addr = 16'h00A0;
        pulses = 0; stall_low = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (host_rsp_valid) pulses++;
            if (!cpu_stall) stall_low = 1;
            en = host_ready;
            @(posedge clock); #1;
            if (en) host_addr = host_addr + 16'd1;
        end
        host_valid = 0;
        chk("lit_halt_pulses", pulses, 4);
        chk("lit_halt_stall", stall_low, 0);
        chk("lit_halt_cnt", stall_cycles, 0);
        host_halt = 0;

        // Protected region
        cpu_op(16'h0010, 16'h5555, en, we);
        chk("lit_prot_en", en, 1);
        chk("lit_prot_we", we, 0);
        chk("lit_prot_fault", prot_fault, 1);
        chk("lit_prot_release", cpu_stall, 0);
        cpu_op(16'h0200, 16'h5555, en, we);
        chk("lit_open_we", we, 1);
        chk("lit_fault_sticky", prot_fault, 1);
        cpu_read(16'h0010, d);
        chk("lit_prot_kept", d, 16'h0010 * 3 ^ 16'hA5A5);

        // Reset during a host read's completion cycle
        host_req(0, 16'h0040, 16'h0000, 1);
        @(posedge clock); #1 reset = 0;
        @(negedge clock);
        chk("lit_abort_cnt", stall_cycles, 0);
        chk("lit_abort_fault", prot_fault, 0);
        chk("lit_abort_cpu_first", ram_en && !host_ready, 1);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            @(posedge clock); #1;
            if (reset) reset = 0;
            else if ($urandom_range(0, 150) == 0) reset = 1;
            if (!obs_stall) begin
                cpu_addr  = $urandom_range(0, 1) ? 16'(16'h00F8 + $urandom_range(0, 15))
                                                 : 16'(16'h0040 + $urandom_range(0, 3));
                cpu_write = ($urandom_range(0, 3) == 0);
                cpu_wdata = 16'($urandom);
                cpu_code  = 1'($urandom);
            end
            if (host_valid && obs_ready) host_valid = 0;
            if (!host_valid && $urandom_range(0, 2) == 0) begin
                host_valid = 1;
                host_write = 1'($urandom);
                host_addr  = 16'(16'h00F8 + $urandom_range(0, 15));
                host_wdata = 16'($urandom);
            end
            if ($urandom_range(0, 15) == 0) host_halt = ~host_halt;
        end

        // Saturation with CNT_W=4
        reset_hold();
        reset = 0;
        repeat (40) @(posedge clock);
        @(negedge clock);
        chk("lit_sat", stall_cycles, 15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hera_mem_arbiter.md
# hera_mem_arbiter

Shares the HERA core's single memory port with a host loader/debug port over one synchronous single-port SRAM with 1-cycle read latency. The core stalls via `cpu_stall` while the arbiter serves it or the host. The block also enforces a write-protected low code region and keeps a saturating stall counter for bring-up. It sits between `hera` and the block RAM on the FPGA top level.

## Interface
- `PROT_TOP`, default 16'h0100: CPU writes to addresses below this are suppressed.
- `CNT_W`, default 32: width of `stall_cycles`.
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high; clock is `clock`.
- `cpu_addr` in 16: core address, held stable while stalled.
- `cpu_code` in 1: access is an instruction fetch.
- `cpu_write` in 1: core store.
- `cpu_wdata` in 16: core store data.
- `cpu_rdata` out 16: read data, valid only while `cpu_stall`=0.
- `cpu_stall` out 1: core must not advance; the core's clock enable is `!cpu_stall`.
- `host_halt` in 1: when high, the CPU is never granted.
- `host_valid` in 1: host request pending.
- `host_ready` out 1: request accepted this cycle.
- `host_write` in 1: host write.
- `host_addr` in 16: host address.
- `host_wdata` in 16: host write data.
- `host_rsp_valid` out 1: one-cycle pulse completing a host access; read data or write ack.
- `host_rdata` out 16: host read data, valid with `host_rsp_valid`.
- `ram_en` out 1: SRAM enable.
- `ram_we` out 1: SRAM write enable.
- `ram_addr` out 16: SRAM address.
- `ram_wdata` out 16: SRAM write data.
- `ram_rdata` in 16: SRAM read data, registered in the SRAM, valid the cycle after `ram_en`.
- `prot_fault` out 1: sticky; set by a suppressed CPU write.
- `stall_cycles` out CNT_W: count of cycles with `cpu_stall`=1 and `host_halt`=0, saturating.

## Operation
- FSM states: ARB, CPU_DONE, HOST_DONE. Every grant takes exactly 2 cycles: an issue cycle (ARB) and a completion cycle.
- The CPU requests in every cycle; the core has no idle bus cycle.
- Grant decision in ARB:
  - `host_halt`=1: host if `host_valid`, else idle (no `ram_en`).
  - `host_halt`=0, no `host_valid`: CPU.
  - `host_halt`=0, `host_valid`=1: the requester not granted last (`last_host` flag) wins. This gives strict alternation.
- CPU issue:
  - `ram_en`=1, `ram_addr`=`cpu_addr`, `ram_wdata`=`cpu_wdata`.
  - `ram_we`=`cpu_write` && `cpu_addr`>=PROT_TOP.
  - If `cpu_write` && `cpu_addr`<PROT_TOP: `ram_we`=0 and `prot_fault` is set on the next edge.
  - `cpu_code` does not affect protection. Next state is CPU_DONE.
- CPU_DONE: `cpu_stall`=0, `cpu_rdata`=`ram_rdata` (combinational), `ram_en`=0, then ARB.
- Host issue:
  - `host_ready`=1, `ram_en`=1, `ram_we`=`host_write`, address/data from the host. The host ignores protection.
  - The host request is captured into a 1-bit pending register. Next state is HOST_DONE.
- HOST_DONE: `host_rsp_valid`=1, `host_rdata`=`ram_rdata` (undefined for writes), then ARB.
- `cpu_stall`=1 in every state except CPU_DONE.
- `stall_cycles`:
  - Increments when `cpu_stall`=1 && `host_halt`=0.
  - Saturates at all-ones.
  - Clears only on reset.
- `prot_fault` clears only on reset.

## Timing
- Reset values: state ARB, `last_host`=1 so the CPU wins first, `cpu_stall`=1, `host_ready`=0, `host_rsp_valid`=0, `ram_en`=0, `ram_we`=0, `prot_fault`=0, `stall_cycles`=0. `cpu_rdata` and `host_rdata` are don't-care.
- CPU access latency is 2 cycles. With no host traffic, `cpu_stall` toggles 1,0,1,0 starting with 1 in the first cycle after reset release.
- Host latency: `host_rsp_valid` is asserted exactly 1 cycle after `host_ready`. `host_valid` may drop only after `host_ready`.
- Host under contention: at most 2 cycles of wait from `host_valid` to `host_ready`.
- `host_halt` rising while the FSM is in CPU_DONE: that completion still finishes. `host_halt` is sampled only in ARB.
- Reset mid-access: the access is aborted and no `host_rsp_valid` is issued. An SRAM write already issued is not undone.
- A `host_valid` that arrives during a completion cycle is considered in the following ARB.

## Structure
- Shared package `hera_mem_pkg`: state enum (ARB, CPU_DONE, HOST_DONE) and the default PROT_TOP constant.
- Single module. No sub-module is warranted; the saturating counter stays inline.

## Test plan
- Reset, SRAM[0x0000]=0x1234, CPU reads 0x0000 -> `ram_en` in cycle 1, `cpu_stall`=0 with `cpu_rdata`=0x1234 in cycle 2, pattern 1,0 repeating.
- Host writes 0x0040<=0xBEEF while the CPU fetches -> grants CPU, host, CPU. `host_rsp_valid` 1 cycle after `host_ready`. A following CPU read of 0x0040 returns 0xBEEF.
- `host_halt`=1 with 4 back-to-back host reads -> `cpu_stall` stays 1, 4 `host_rsp_valid` pulses in 8 cycles, `stall_cycles` unchanged.
- CPU write 0x5555 to 0x0010 -> `ram_we`=0, `prot_fault`=1 and stays set, stall released normally. CPU write to 0x0200 -> `ram_we`=1.
- Reset asserted in HOST_DONE of a host read -> no `host_rsp_valid`, next cycle state ARB, `stall_cycles`=0, `prot_fault`=0.
- Force `stall_cycles` near all-ones (CNT_W=4) -> counts to 15 and holds.
